// File: rtl/uart_imem_loader_pkg.sv
// Shared state encodings and default constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_RECV,
        LD_WRITE,
        LD_DONE
    } ld_state_e;

    localparam int unsigned DEF_CLKS_PER_BIT = 434;
    localparam logic [31:0] DEF_STOP_WORD    = 32'h0000_0FFF;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop input synchroniser, bit timer and RX FSM.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q;
    rx_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {sync2_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    valid_d = sync2_q;
                    ferr_d  = ~sync2_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign byte_o       = shreg_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes into little-endian words, writes them to imem and
// holds the core in reset until a terminator word arrives or imem is full.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned ADDR_W       = 8,
    parameter logic [31:0] STOP_WORD    = DEF_STOP_WORD
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en_i,
    input  logic              rx_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              frame_err_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr)
    );

    ld_state_e         state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              core_rst_q, core_rst_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        done_d     = done_q;
        ferr_d     = ferr_q | rx_ferr;

        // Disable overrides everything, including a byte landing this same cycle.
        if (!en_i) begin
            state_d    = LD_IDLE;
            byte_cnt_d = '0;
            addr_d     = '0;
            done_d     = 1'b0;
        end else begin
            unique case (state_q)
                LD_IDLE: state_d = LD_RECV;
                LD_RECV: begin
                    if (rx_valid) begin
                        word_d[8*byte_cnt_q +: 8] = rx_byte;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 2'd3) begin
                            if (word_d == STOP_WORD) begin
                                done_d  = 1'b1;
                                state_d = LD_DONE;
                            end else begin
                                we_d    = 1'b1;
                                wdata_d = word_d;
                                state_d = LD_WRITE;
                            end
                        end
                    end
                end
                LD_WRITE: begin
                    if (addr_q == '1) begin
                        done_d  = 1'b1;
                        state_d = LD_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = LD_RECV;
                    end
                end
                LD_DONE: state_d = LD_DONE;
                default: state_d = LD_IDLE;
            endcase
        end

        core_rst_d = en_i & ~done_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= LD_IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign core_rst_o   = core_rst_q;
    assign done_o       = done_q;
    assign frame_err_o  = ferr_q;

endmodule
